// File: rtl/ps2_ascii_queue.sv
// PS/2 Set-2 scan-code to ASCII decoder with prefix tracking, Shift/Caps state,
// optional typematic-repeat suppression and a first-word-fall-through character FIFO.
module ps2_ascii_queue #(
    parameter int DEPTH     = 8,
    parameter bit REPEAT_EN = 1'b1,
    parameter bit EXT_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       rd_en,
    output logic [7:0] ascii,
    output logic       ascii_valid,
    output logic       fifo_full,
    output logic       overflow,
    output logic       shift_active,
    output logic       caps_lock
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    state_t      state, state_nx;
    logic        shift_l, shift_r, caps, caps_held;
    logic        shift_l_nx, shift_r_nx, caps_nx, caps_held_nx;
    logic [7:0]  held_key, held_nx;
    logic        push_req;
    logic [7:0]  push_char;
    logic [8:0]  mapped;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_ok;

    // Returns {mapped, character}; unmapped codes give 9'h000.
    function automatic logic [8:0] map_key(input logic [7:0] code, input logic shift,
                                           input logic upper);
        logic [7:0] c;
        c = 8'h00;
        case (code)
            8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
            8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
            8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
            8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
            8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
            8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
            8'h35: c = "y";  8'h1A: c = "z";
            8'h16: c = shift ? "!" : "1";
            8'h1E: c = shift ? "@" : "2";
            8'h26: c = shift ? "#" : "3";
            8'h25: c = shift ? "$" : "4";
            8'h2E: c = shift ? "%" : "5";
            8'h36: c = shift ? "^" : "6";
            8'h3D: c = shift ? "&" : "7";
            8'h3E: c = shift ? "*" : "8";
            8'h46: c = shift ? "(" : "9";
            8'h45: c = shift ? ")" : "0";
            8'h4E: c = shift ? "_" : "-";
            8'h55: c = shift ? "+" : "=";
            8'h0E: c = shift ? "~" : 8'h60;
            8'h54: c = shift ? "{" : "[";
            8'h5B: c = shift ? "}" : "]";
            8'h4C: c = shift ? ":" : ";";
            8'h52: c = shift ? "\"" : "'";
            8'h41: c = shift ? "<" : ",";
            8'h49: c = shift ? ">" : ".";
            8'h4A: c = shift ? "?" : "/";
            8'h5D: c = shift ? "|" : "\\";
            8'h29: c = " ";
            8'h5A: c = 8'h0D;
            8'h66: c = 8'h08;
            default: c = 8'h00;
        endcase
        if (upper && c >= "a" && c <= "z")
            c = c - 8'h20;
        return {c != 8'h00, c};
    endfunction

    assign shift_active = shift_l | shift_r;
    assign caps_lock    = caps;

    always_comb begin
        state_nx     = state;
        shift_l_nx   = shift_l;
        shift_r_nx   = shift_r;
        caps_nx      = caps;
        caps_held_nx = caps_held;
        held_nx      = held_key;
        push_req     = 1'b0;
        push_char    = 8'h00;
        mapped       = 9'h000;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == 8'hF0)
                        state_nx = BREAK;
                    else if (scan_code == 8'hE0)
                        state_nx = EXT;
                    else begin
                        case (scan_code)
                            8'h12: shift_l_nx = 1'b1;
                            8'h59: shift_r_nx = 1'b1;
                            8'h58: begin
                                if (!caps_held)
                                    caps_nx = !caps;
                                caps_held_nx = 1'b1;
                            end
                            default: begin
                                held_nx = scan_code;
                                if (REPEAT_EN || scan_code != held_key) begin
                                    mapped    = map_key(scan_code, shift_active,
                                                        shift_active ^ caps);
                                    push_req  = mapped[8];
                                    push_char = mapped[7:0];
                                end
                            end
                        endcase
                    end
                end
                BREAK: begin
                    if (scan_code == 8'hE0)
                        state_nx = EXT_BREAK;
                    else if (scan_code != 8'hF0) begin
                        state_nx = IDLE;
                        case (scan_code)
                            8'h12:   shift_l_nx   = 1'b0;
                            8'h59:   shift_r_nx   = 1'b0;
                            8'h58:   caps_held_nx = 1'b0;
                            default: if (scan_code == held_key) held_nx = 8'h00;
                        endcase
                    end
                end
                EXT: begin
                    if (scan_code == 8'hF0)
                        state_nx = EXT_BREAK;
                    else begin
                        state_nx = IDLE;
                        // Only keypad Enter and keypad slash produce characters.
                        if (EXT_EN && scan_code == 8'h5A) begin
                            push_req  = 1'b1;
                            push_char = 8'h0D;
                        end else if (EXT_EN && scan_code == 8'h4A) begin
                            push_req  = 1'b1;
                            push_char = "/";
                        end
                    end
                end
                EXT_BREAK: begin
                    if (scan_code != 8'hF0)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr - rd_ptr) == FULL_CNT);
    assign pop     = rd_en && !empty;
    assign push_ok = push_req && (!full || pop);

    assign ascii       = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign ascii_valid = !empty;
    assign fifo_full   = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
            held_key  <= 8'h00;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_l   <= shift_l_nx;
            shift_r   <= shift_r_nx;
            caps      <= caps_nx;
            caps_held <= caps_held_nx;
            held_key  <= held_nx;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

    // When full with a simultaneous pop, the write slot is the head being popped.
    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            mem[wr_ptr[AW-1:0]] <= push_char;
    end

endmodule

// File: tb/tb_ps2_ascii_queue.sv
// Bench for ps2_ascii_queue: two configurations driven by the same byte stream,
// checked by directed scenarios and a randomized run against a behavioural model.
module tb_ps2_ascii_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       rd_a = 1'b0, rd_b = 1'b0;

    logic [7:0] a_ascii, b_ascii;
    logic       a_valid, a_full, a_ovf, a_shift, a_caps;
    logic       b_valid, b_full, b_ovf, b_shift, b_caps;
    logic [12:0] a_vec, b_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_ascii_queue #(.DEPTH(8), .REPEAT_EN(1'b1), .EXT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid), .rd_en(rd_a),
        .ascii(a_ascii), .ascii_valid(a_valid), .fifo_full(a_full), .overflow(a_ovf),
        .shift_active(a_shift), .caps_lock(a_caps));

    ps2_ascii_queue #(.DEPTH(4), .REPEAT_EN(1'b0), .EXT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid), .rd_en(rd_b),
        .ascii(b_ascii), .ascii_valid(b_valid), .fifo_full(b_full), .overflow(b_ovf),
        .shift_active(b_shift), .caps_lock(b_caps));

    assign a_vec = {a_ascii, a_valid, a_full, a_ovf, a_shift, a_caps};
    assign b_vec = {b_ascii, b_valid, b_full, b_ovf, b_shift, b_caps};

    // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------------
    logic [7:0] lo_tab [256];
    logic [7:0] hi_tab [256];
    bit         is_letter [256];
    bit         is_mapped [256];

    bit         m_brk [2], m_ext [2], m_shl [2], m_shr [2], m_caps [2], m_ch [2], m_ovf [2];
    logic [7:0] m_held [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    logic [7:0] pool [20] = '{8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h1E, 8'h1A,
                              8'h29, 8'h5A, 8'h66, 8'h4A, 8'h16, 8'h4E, 8'h5D, 8'h52, 8'h07, 8'h75};

    function automatic int depth_of(input int m);
        return (m == 0) ? 8 : 4;
    endfunction

    task automatic init_tables();
        string letters, pu, ps;
        logic [7:0] lcodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] pcodes [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                    8'h45, 8'h4E, 8'h55, 8'h0E, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41,
                                    8'h49, 8'h4A, 8'h5D};
        letters = "abcdefghijklmnopqrstuvwxyz";
        pu = "1234567890-=`[];',./\\";
        ps = "!@#$%^&*()_+~{}:\"<>?|";
        for (int i = 0; i < 256; i++) begin
            lo_tab[i] = 8'h00; hi_tab[i] = 8'h00; is_letter[i] = 1'b0; is_mapped[i] = 1'b0;
        end
        for (int i = 0; i < 26; i++) begin
            lo_tab[lcodes[i]] = letters[i];
            hi_tab[lcodes[i]] = letters[i] - 8'd32;
            is_letter[lcodes[i]] = 1'b1;
            is_mapped[lcodes[i]] = 1'b1;
        end
        for (int i = 0; i < 21; i++) begin
            lo_tab[pcodes[i]] = pu[i];
            hi_tab[pcodes[i]] = ps[i];
            is_mapped[pcodes[i]] = 1'b1;
        end
        lo_tab[8'h29] = " ";   hi_tab[8'h29] = " ";   is_mapped[8'h29] = 1'b1;
        lo_tab[8'h5A] = 8'h0D; hi_tab[8'h5A] = 8'h0D; is_mapped[8'h5A] = 1'b1;
        lo_tab[8'h66] = 8'h08; hi_tab[8'h66] = 8'h08; is_mapped[8'h66] = 1'b1;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_brk[m] = 0; m_ext[m] = 0; m_shl[m] = 0; m_shr[m] = 0;
            m_caps[m] = 0; m_ch[m] = 0; m_ovf[m] = 0; m_held[m] = 8'h00;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_push(input int m, input logic [7:0] c);
        int n;
        n = (m == 0) ? q0.size() : q1.size();
        if (n >= depth_of(m)) m_ovf[m] = 1'b1;
        else if (m == 0) q0.push_back(c);
        else q1.push_back(c);
    endtask

    task automatic model_byte(input int m, input logic [7:0] b);
        bit sh, up;
        if (b == 8'hF0) begin
            m_brk[m] = 1'b1;
        end else if (b == 8'hE0 && !m_ext[m]) begin
            m_ext[m] = 1'b1;
        end else begin
            if (!m_brk[m] && !m_ext[m]) begin
                if (b == 8'h12) m_shl[m] = 1'b1;
                else if (b == 8'h59) m_shr[m] = 1'b1;
                else if (b == 8'h58) begin
                    if (!m_ch[m]) m_caps[m] = !m_caps[m];
                    m_ch[m] = 1'b1;
                end else begin
                    if (!(m == 1 && b == m_held[m]) && is_mapped[b]) begin
                        sh = m_shl[m] | m_shr[m];
                        up = is_letter[b] ? (sh ^ m_caps[m]) : sh;
                        model_push(m, up ? hi_tab[b] : lo_tab[b]);
                    end
                    m_held[m] = b;
                end
            end else if (m_brk[m] && !m_ext[m]) begin
                if (b == 8'h12) m_shl[m] = 1'b0;
                else if (b == 8'h59) m_shr[m] = 1'b0;
                else if (b == 8'h58) m_ch[m] = 1'b0;
                else if (b == m_held[m]) m_held[m] = 8'h00;
            end else if (!m_brk[m] && m_ext[m] && m == 0) begin
                if (b == 8'h5A) model_push(m, 8'h0D);
                else if (b == 8'h4A) model_push(m, "/");
            end
            m_brk[m] = 1'b0;
            m_ext[m] = 1'b0;
        end
    endtask

    function automatic logic [12:0] exp_vec(input int m);
        int n;
        logic [7:0] h;
        n = (m == 0) ? q0.size() : q1.size();
        h = 8'h00;
        if (n > 0) h = (m == 0) ? q0[0] : q1[0];
        return {h, n > 0, n == depth_of(m), m_ovf[m], m_shl[m] | m_shr[m], m_caps[m]};
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input logic [7:0] code, input logic v, input logic ra, input logic rb);
        scan_code = code; scan_valid = v; rd_a = ra; rd_b = rb;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (ra && q0.size() > 0) void'(q0.pop_front());
            if (rb && q1.size() > 0) void'(q1.pop_front());
            if (v) begin
                model_byte(0, code);
                model_byte(1, code);
            end
        end
        #1;
        scan_valid = 1'b0; rd_a = 1'b0; rd_b = 1'b0;
    endtask

    task automatic send(input logic [7:0] code);
        step(code, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            step(8'($urandom), 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (a_vec !== 13'h0) begin errors++; $display("FAIL reset_a got=%h exp=%h", a_vec, 13'h0); end
        checks++;
        if (b_vec !== 13'h0) begin errors++; $display("FAIL reset_b got=%h exp=%h", b_vec, 13'h0); end
        send(8'h1C); send(8'h32); send(8'hF0);
        do_reset();
        checks++;
        if (a_vec !== 13'h0) begin errors++; $display("FAIL reset_mid_a got=%h exp=%h", a_vec, 13'h0); end
        send(8'h1C);
        checks++;
        if ({a_valid, a_ascii} !== {1'b1, 8'h61}) begin
            errors++; $display("FAIL reset_prefix_a got=%b/%h exp=1/61", a_valid, a_ascii);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send(8'h1C);
        checks++;
        if ({a_valid, a_ascii} !== {1'b1, 8'h61}) begin
            errors++; $display("FAIL basic_latency_a got=%b/%h exp=1/61", a_valid, a_ascii);
        end
        send(8'hF0); send(8'h1C);
        checks++;
        if ({b_valid, b_ascii} !== {1'b1, 8'h61}) begin
            errors++; $display("FAIL basic_head_b got=%b/%h exp=1/61", b_valid, b_ascii);
        end
        step(8'h00, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({a_valid, a_ascii} !== 9'h0) begin
            errors++; $display("FAIL basic_pop_a got=%b/%h exp=0/00", a_valid, a_ascii);
        end
        checks++;
        if ({b_valid, b_ascii} !== 9'h0) begin
            errors++; $display("FAIL basic_pop_b got=%b/%h exp=0/00", b_valid, b_ascii);
        end
        step(8'h00, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({a_valid, a_full, a_ovf} !== 3'b000) begin
            errors++; $display("FAIL basic_empty_rd got=%b exp=000", {a_valid, a_full, a_ovf});
        end
    endtask

    task automatic test_shift();
        logic [7:0] exp [2] = '{"@", "2"};
        do_reset();
        send(8'h12);
        checks++;
        if ({a_shift, b_shift} !== 2'b11) begin
            errors++; $display("FAIL shift_set got=%b exp=11", {a_shift, b_shift});
        end
        send(8'h1E); send(8'hF0); send(8'h1E);
        checks++;
        if (a_shift !== 1'b1) begin errors++; $display("FAIL shift_hold got=%b exp=1", a_shift); end
        send(8'hF0); send(8'h12);
        checks++;
        if ({a_shift, b_shift} !== 2'b00) begin
            errors++; $display("FAIL shift_clear got=%b exp=00", {a_shift, b_shift});
        end
        send(8'h1E);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({a_valid, a_ascii} !== {1'b1, exp[i]}) begin
                errors++; $display("FAIL shift_q_a[%0d] got=%b/%h exp=1/%h", i, a_valid, a_ascii, exp[i]);
            end
            checks++;
            if ({b_valid, b_ascii} !== {1'b1, exp[i]}) begin
                errors++; $display("FAIL shift_q_b[%0d] got=%b/%h exp=1/%h", i, b_valid, b_ascii, exp[i]);
            end
            step(8'h00, 1'b0, 1'b1, 1'b1);
        end
        checks++;
        if ({a_valid, b_valid} !== 2'b00) begin
            errors++; $display("FAIL shift_drained got=%b exp=00", {a_valid, b_valid});
        end
    endtask

    task automatic test_caps();
        do_reset();
        send(8'h58);
        checks++;
        if ({a_caps, b_caps} !== 2'b11) begin
            errors++; $display("FAIL caps_toggle got=%b exp=11", {a_caps, b_caps});
        end
        send(8'h58);
        checks++;
        if (a_caps !== 1'b1) begin errors++; $display("FAIL caps_held got=%b exp=1", a_caps); end
        send(8'hF0); send(8'h58); send(8'h1C); send(8'h12); send(8'h1C);
        checks++;
        if ({a_valid, a_ascii, b_valid, b_ascii} !== {1'b1, 8'h41, 1'b1, 8'h41}) begin
            errors++; $display("FAIL caps_head got=%h/%h exp=41/41", a_ascii, b_ascii);
        end
        step(8'h00, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({a_valid, a_ascii, b_valid} !== {1'b1, 8'h61, 1'b0}) begin
            errors++; $display("FAIL caps_second got=%b/%h,%b exp=1/61,0", a_valid, a_ascii, b_valid);
        end
        step(8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({a_valid, a_caps} !== 2'b01) begin
            errors++; $display("FAIL caps_end got=%b exp=01", {a_valid, a_caps});
        end
    endtask

    task automatic test_repeat();
        int na, nb;
        logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        do_reset();
        foreach (seq[i]) send(seq[i]);
        na = 0; nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_valid && a_ascii == 8'h61) na++;
            if (b_valid && b_ascii == 8'h61) nb++;
            step(8'h00, 1'b0, 1'b1, 1'b1);
        end
        checks++;
        if (na != 4) begin errors++; $display("FAIL repeat_on got=%0d exp=4", na); end
        checks++;
        if (nb != 2) begin errors++; $display("FAIL repeat_off got=%0d exp=2", nb); end
    endtask

    task automatic test_ext();
        logic [7:0] seq [9] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h5A, 8'h07, 8'h1C};
        do_reset();
        foreach (seq[i]) send(seq[i]);
        checks++;
        if ({a_valid, a_ascii} !== {1'b1, 8'h0D}) begin
            errors++; $display("FAIL ext_on_head got=%b/%h exp=1/0d", a_valid, a_ascii);
        end
        checks++;
        if ({b_valid, b_ascii} !== {1'b1, 8'h61}) begin
            errors++; $display("FAIL ext_off_head got=%b/%h exp=1/61", b_valid, b_ascii);
        end
        step(8'h00, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({a_valid, a_ascii, b_valid} !== {1'b1, 8'h61, 1'b0}) begin
            errors++; $display("FAIL ext_idle got=%b/%h,%b exp=1/61,0", a_valid, a_ascii, b_valid);
        end
        step(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
        logic [7:0] chars [5] = '{"a", "b", "c", "d", "e"};
        logic [7:0] after [4] = '{"b", "c", "d", "n"};
        do_reset();
        for (int i = 0; i < 4; i++) send(codes[i]);
        checks++;
        if ({b_full, b_ovf} !== 2'b10) begin
            errors++; $display("FAIL ovf_full4 got=%b exp=10", {b_full, b_ovf});
        end
        send(codes[4]);
        checks++;
        if ({b_full, b_ovf, a_full, a_ovf} !== 4'b1100) begin
            errors++; $display("FAIL ovf_drop got=%b exp=1100", {b_full, b_ovf, a_full, a_ovf});
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({a_valid, a_ascii} !== {1'b1, chars[i]}) begin
                errors++; $display("FAIL ovf_a[%0d] got=%b/%h exp=1/%h", i, a_valid, a_ascii, chars[i]);
            end
            checks++;
            if ({b_valid, b_ascii} !== ((i < 4) ? {1'b1, chars[i]} : 9'h0)) begin
                errors++; $display("FAIL ovf_b[%0d] got=%b/%h", i, b_valid, b_ascii);
            end
            step(8'h00, 1'b0, 1'b1, 1'b1);
        end
        checks++;
        if ({b_ovf, b_valid} !== 2'b10) begin
            errors++; $display("FAIL ovf_sticky got=%b exp=10", {b_ovf, b_valid});
        end
        do_reset();
        checks++;
        if (b_ovf !== 1'b0) begin errors++; $display("FAIL ovf_rst got=%b exp=0", b_ovf); end
        for (int i = 0; i < 4; i++) send(codes[i]);
        step(8'h31, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({b_full, b_ovf, b_ascii} !== {2'b10, 8'h62}) begin
            errors++; $display("FAIL ovf_pushpop got=%b/%h exp=10/62", {b_full, b_ovf}, b_ascii);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({b_valid, b_ascii} !== {1'b1, after[i]}) begin
                errors++; $display("FAIL ovf_pp_b[%0d] got=%b/%h exp=1/%h", i, b_valid, b_ascii, after[i]);
            end
            step(8'h00, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [7:0] code;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                code = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
                step(code, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0);
            end
            checks++;
            if (a_vec !== exp_vec(0)) begin
                errors++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", i, a_vec, exp_vec(0));
            end
            checks++;
            if (b_vec !== exp_vec(1)) begin
                errors++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", i, b_vec, exp_vec(1));
            end
        end
    endtask

    initial begin
        init_tables();
        model_reset();
        test_reset();
        test_basic();
        test_shift();
        test_caps();
        test_repeat();
        test_ext();
        test_overflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_ascii_queue.md
Name: ps2_ascii_queue

Overview:
Next-generation PS/2 scan-code decoder that converts Set-2 byte streams into ASCII characters and queues them. It tracks the make/break/extended prefixes, Shift and Caps Lock state, and optionally suppresses typematic repeats. Decoded characters go into a first-word-fall-through FIFO. The block sits between the PS/2 byte receiver and the text/console consumer.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
REPEAT_EN, 1, 1 = typematic repeats enqueue again; 0 = repeats of the held key are dropped
EXT_EN, 1, 1 = E0 5A enqueues 8'h0D and E0 4A enqueues "/"; 0 = all E0 keys are ignored

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
scan_code  in  8  byte from the PS/2 receiver
scan_valid  in  1  one-cycle strobe; scan_code is valid in that cycle
rd_en  in  1  pop request; ignored when the FIFO is empty
ascii  out  8  FIFO head character; 8'h00 when empty
ascii_valid  out  1  FIFO not empty
fifo_full  out  1  count == DEPTH
overflow  out  1  sticky; set when a character is dropped because the FIFO is full
shift_active  out  1  left or right Shift is held
caps_lock  out  1  Caps Lock toggle state

Behaviour:
- Reset values:
  - FSM = IDLE.
  - FIFO is empty.
  - ascii = 0, ascii_valid = 0, fifo_full = 0, overflow = 0.
  - shift_active = 0, caps_lock = 0.
  - Held-key register = 8'h00, caps_held = 0.
- Reset takes priority over all inputs, including in the middle of a prefix sequence or a FIFO operation.
- Byte FSM (advances only on scan_valid):
  - IDLE: F0 -> BREAK; E0 -> EXT; any other byte is a make code and returns to IDLE.
  - BREAK: the next byte is a break code; process it, then IDLE.
  - EXT: F0 -> EXT_BREAK; any other byte is an extended make code, then IDLE.
  - EXT_BREAK: the next byte is an extended break code (never enqueued), then IDLE.
  - A repeated F0 in BREAK or EXT_BREAK stays in that state. E0 in BREAK goes to EXT_BREAK.
- Modifiers (never enqueued):
  - 12/59 make sets the left/right Shift flag; 12/59 break clears it.
  - shift_active = left | right.
  - 58 make toggles caps_lock only when caps_held = 0, then sets caps_held. 58 break clears caps_held.
- Held key:
  - A non-modifier make code updates the held-key register.
  - A break of the same code clears it to 8'h00.
- Repeat suppression: when REPEAT_EN = 0, a make code equal to the held key is dropped.
- Mapping (US layout):
  - Letters 1C..1A (a..z) produce uppercase when shift_active XOR caps_lock, otherwise lowercase.
  - Digits and punctuation produce their shifted form only when shift_active; caps_lock has no effect on them.
    - 1! 2@ 3# 4$ 5% 6^ 7& 8* 9( 0) -_ =+ `~ [{ ]} ;: '" ,< .> /? \|
  - 29 -> " ", 5A -> 8'h0D, 66 -> 8'h08.
  - Unmapped make codes are dropped; nothing is enqueued (no 8'hFF).
  - Break codes never enqueue.
- Latency: a scan_valid edge that enqueues at cycle N produces ascii_valid = 1 and ascii equal to the character at cycle N+1 (when the FIFO was empty).
- FIFO:
  - Pointers are log2(DEPTH)+1 bits, wrapping modulo 2·DEPTH.
  - rd_en with ascii_valid = 1 pops; the next head appears the following cycle.
  - Simultaneous push and pop is always legal, including when full: count is unchanged and no overflow occurs.
  - Push when full without pop: the character is dropped and overflow is set. overflow clears only on rst.
  - rd_en when empty is a no-op.

Test Plan:
- Reset then bytes 1C, F0, 1C -> one entry "a" (8'h61), ascii_valid high one cycle after the 1C strobe; after rd_en, ascii_valid = 0 and ascii = 0.
- 12, 1E, F0 1E, F0 12, 1E -> FIFO holds "@" then "2"; shift_active = 1 between the 12 make and the 12 break.
- 58, F0 58, 1C, 12, 1C -> caps_lock = 1; FIFO holds "A" then "a". A second 58 sent while caps is held (no break) does not toggle.
- REPEAT_EN = 0: 1C, 1C, 1C, F0 1C, 1C -> FIFO holds "a" twice. REPEAT_EN = 1: same stimulus -> four entries.
- E0 75, E0 F0 75, E0 5A, 07 -> with EXT_EN = 1 the FIFO holds only 8'h0D; 07 (unmapped) adds nothing; FSM ends in IDLE.
- DEPTH = 4: enqueue 5 chars without reads -> fifo_full = 1, overflow = 1, and pops return the first 4 in order. Push and pop in the same cycle while full -> overflow stays clear if it was clear before, count stays 4.
